// File: rtl/ir_nec_decoder_if.sv
// IR NEC decoder bus: raw receiver line in, decoded command out.
// master = decoder side, slave = consumer/driver side.
interface ir_nec_decoder_if;
   logic        ir_rx;
   logic [31:0] ir_command;
   logic        ir_data_ready;
   logic        ir_error;

   modport master (
      input  ir_rx,
      output ir_command,
      output ir_data_ready,
      output ir_error
   );

   modport slave (
      output ir_rx,
      input  ir_command,
      input  ir_data_ready,
      input  ir_error
   );
endinterface

// File: rtl/ir_nec_decoder.sv
// NEC extended IR frame decoder: times marks/spaces in 1 us ticks and
// shifts 32 bits LSB-first into ir_command.
// Ports: clk, rst_n (async, active low), ir_bus (master modport:
//   ir_rx in, ir_command/ir_data_ready/ir_error out).
// Option: define IR_REPEAT_EN to re-announce the last command on a
//   repeat frame.
module ir_nec_decoder #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int TIMEOUT_US = 12000
) (
   input  logic             clk,
   input  logic             rst_n,
   ir_nec_decoder_if.master ir_bus
);

   localparam int RAW = CLK_FREQ / 1_000_000;
   localparam int DIV = (RAW > 1) ? RAW : 1;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [13:0]   TMO  = 14'(TIMEOUT_US);

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK,
      BIT_SPACE, STOP_MARK, REP_MARK
   } state_t;

   function automatic logic win(
      input logic [13:0] d, input int lo, input int hi);
      return (d >= 14'(lo)) && (d <= 14'(hi));
   endfunction

   logic [1:0]    sync_q;
   logic          prev_q;
   logic [PW-1:0] pre_q, pre_d;
   logic [13:0]   dur_q, dur_d;
   state_t        state_q, state_d;
   logic [4:0]    bit_q, bit_d;
   logic [31:0]   sh_q, sh_d;
   logic [31:0]   cmd_q, cmd_d;
   logic          rdy_q, rdy_d;
   logic          err_q, err_d;
`ifdef IR_REPEAT_EN
   logic          have_q, have_d;
`endif

   logic rx, rise, fall, tick, tmo, fail;

   assign rx   = sync_q[1];
   assign rise = rx & ~prev_q;
   assign fall = ~rx & prev_q;
   assign tick = (pre_q == PMAX);
   // Timeout never fires in IDLE, where dur_us just saturates.
   assign tmo  = (state_q != IDLE) && (dur_q >= TMO);

   always_comb begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      dur_d = dur_q;
      if (rise | fall)
         dur_d = '0;
      else if (tick && (dur_q != '1))
         dur_d = dur_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      cmd_d   = cmd_q;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      fail    = 1'b0;
`ifdef IR_REPEAT_EN
      have_d  = have_q;
`endif
      // An edge wins over a coincident timeout.
      unique case (state_q)
         IDLE:
            if (fall) state_d = LEAD_MARK;
         LEAD_MARK:
            if (rise) begin
               if (win(dur_q, 8000, 10000)) state_d = LEAD_SPACE;
               else fail = 1'b1;
            end else if (tmo) fail = 1'b1;
         LEAD_SPACE:
            if (fall) begin
               unique case (1'b1)
                  win(dur_q, 4000, 5000): begin
                     bit_d   = '0;
                     state_d = BIT_MARK;
                  end
                  win(dur_q, 2000, 2500): state_d = REP_MARK;
                  default: fail = 1'b1;
               endcase
            end else if (tmo) fail = 1'b1;
         BIT_MARK:
            if (rise) begin
               if (win(dur_q, 400, 700)) state_d = BIT_SPACE;
               else fail = 1'b1;
            end else if (tmo) fail = 1'b1;
         BIT_SPACE:
            if (fall) begin
               // Fill from the top so the first bit lands in bit 0.
               unique case (1'b1)
                  win(dur_q, 400, 700):   sh_d = {1'b0, sh_q[31:1]};
                  win(dur_q, 1400, 1900): sh_d = {1'b1, sh_q[31:1]};
                  default: fail = 1'b1;
               endcase
               if (!fail) begin
                  bit_d   = bit_q + 1'b1;
                  state_d = (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
               end
            end else if (tmo) fail = 1'b1;
         STOP_MARK:
            if (rise) begin
               if (win(dur_q, 400, 700)) begin
                  cmd_d   = sh_q;
                  rdy_d   = 1'b1;
                  state_d = IDLE;
`ifdef IR_REPEAT_EN
                  have_d  = 1'b1;
`endif
               end else fail = 1'b1;
            end else if (tmo) fail = 1'b1;
         REP_MARK:
            if (rise) begin
               if (win(dur_q, 400, 700)) begin
                  state_d = IDLE;
`ifdef IR_REPEAT_EN
                  rdy_d   = have_q;
`endif
               end else fail = 1'b1;
            end else if (tmo) fail = 1'b1;
         default: state_d = IDLE;
      endcase
      if (fail) begin
         err_d   = 1'b1;
         rdy_d   = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         pre_q   <= '0;
         dur_q   <= '0;
         state_q <= IDLE;
         bit_q   <= '0;
         sh_q    <= '0;
         cmd_q   <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef IR_REPEAT_EN
         have_q  <= 1'b0;
`endif
      end else begin
         sync_q  <= {sync_q[0], ir_bus.ir_rx};
         prev_q  <= sync_q[1];
         pre_q   <= pre_d;
         dur_q   <= dur_d;
         state_q <= state_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         cmd_q   <= cmd_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
`ifdef IR_REPEAT_EN
         have_q  <= have_d;
`endif
      end
   end

   assign ir_bus.ir_command    = cmd_q;
   assign ir_bus.ir_data_ready = rdy_q;
   assign ir_bus.ir_error      = err_q;

endmodule
